// File: rtl/comm_pkg.sv
// Shared definitions for the STM32 report link: scheduler state encoding,
// default word split and the firmware-visible channel tags.
package comm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    SEND = 3'b010,
    GAP  = 3'b100
  } state_t;

  localparam int unsigned DEF_TAG_W  = 4;
  localparam int unsigned DEF_DATA_W = 28;

  localparam logic [DEF_TAG_W-1:0] TAG_FREQ = 4'd0;
  localparam logic [DEF_TAG_W-1:0] TAG_AMP  = 4'd1;
  localparam logic [DEF_TAG_W-1:0] TAG_MOD  = 4'd2;
  localparam logic [DEF_TAG_W-1:0] TAG_MODE = 4'd3;

endpackage

// File: rtl/comm_report_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after 'last', wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 gnt_any,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int unsigned LW = $clog2(N);

  int unsigned idx;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last) + i) % N;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = LW'(idx);
      end
    end
  end

endmodule

// File: rtl/comm_report_scheduler.sv
// Latches per-channel results and feeds them, tagged, to the single serial
// report sender with a fixed hold-off between frame starts.
module comm_report_scheduler
  import comm_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned TAG_W     = DEF_TAG_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned FRAME_CYC = 20000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     ovf_clr,
  output logic                     tx_start,
  output logic [TAG_W+DATA_W-1:0]  tx_word,
  output logic                     busy,
  output logic [NUM_CH-1:0]        ovf,
  output logic [15:0]              frame_cnt
);

  localparam int unsigned IW = $clog2(NUM_CH);
  localparam int unsigned CW = $clog2(FRAME_CYC);

  if (FRAME_CYC < 2) begin : g_chk_frame
    $error("comm_report_scheduler: FRAME_CYC must be >= 2");
  end
  if (NUM_CH < 2 || NUM_CH > 16) begin : g_chk_ch
    $error("comm_report_scheduler: NUM_CH must be in 2..16");
  end
  if (TAG_W < IW) begin : g_chk_tag
    $error("comm_report_scheduler: TAG_W too narrow for NUM_CH");
  end

  state_t                          state, state_next;
  logic [CW-1:0]                   gap_cnt, gap_cnt_next;
  logic [NUM_CH-1:0][DATA_W-1:0]   hold;
  logic [NUM_CH-1:0]               pend, pend_next, ovf_set, elig;
  logic [IW-1:0]                   last, gnt_idx;
  logic                            gnt_any, fire;

  assign elig = pend & ch_en;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .req     (elig),
    .last    (last),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx)
  );

  // The final GAP cycle may grant directly so back-to-back starts are
  // exactly FRAME_CYC apart; otherwise it falls back to IDLE.
  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    fire         = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_any) begin
          fire       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        gap_cnt_next = CW'(FRAME_CYC - 2);
        state_next   = GAP;
      end
      GAP: begin
        if (gap_cnt == '0) begin
          if (gnt_any) begin
            fire       = 1'b1;
            state_next = SEND;
          end else begin
            state_next = IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A capture on the channel being granted re-arms pend without overflow.
  always_comb begin
    pend_next = pend;
    ovf_set   = '0;
    if (fire) pend_next[gnt_idx] = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (in_valid[k]) begin
        pend_next[k] = 1'b1;
        if (pend[k] && !(fire && gnt_idx == IW'(k))) ovf_set[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      hold      <= '0;
      pend      <= '0;
      ovf       <= '0;
      last      <= IW'(NUM_CH - 1);
      tx_start  <= 1'b0;
      tx_word   <= '0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state    <= state_next;
      gap_cnt  <= gap_cnt_next;
      pend     <= pend_next;
      ovf      <= (ovf & ~{NUM_CH{ovf_clr}}) | ovf_set;
      tx_start <= fire;
      busy     <= (state_next != IDLE);
      if (fire) begin
        tx_word   <= {TAG_W'(gnt_idx), hold[gnt_idx]};
        last      <= gnt_idx;
        frame_cnt <= frame_cnt + 16'd1;
      end
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (in_valid[k]) hold[k] <= in_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule
